// File: rtl/alu_pkg.sv
// Shared types for the ALU operand stage: ALU function codes, RV32I opcodes, decoded entry.
// Pure declarations; no timing or flow control of its own.
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_REG_W = 5;

  typedef enum logic [3:0] {
    FUN_ADD  = 4'b0000,
    FUN_SLL  = 4'b0001,
    FUN_SLT  = 4'b0010,
    FUN_SLTU = 4'b0011,
    FUN_XOR  = 4'b0100,
    FUN_SRL  = 4'b0101,
    FUN_OR   = 4'b0110,
    FUN_AND  = 4'b0111,
    FUN_SUB  = 4'b1000,
    FUN_LUI  = 4'b1001,
    FUN_SRA  = 4'b1101
  } alu_fun_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [ALU_XLEN-1:0]  a;
    logic [ALU_XLEN-1:0]  b;
    logic [3:0]           fun;
    logic [ALU_REG_W-1:0] rd;
    logic                 rd_we;
    logic                 illegal;
  } dec_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// RV32I immediate builder (I/S/U formats), sign-extended from bit 31; purely combinational.
// Takes only instr[31:7] since the opcode field carries no immediate bits.
module rv32_imm_gen
  import alu_pkg::*;
(
  input  logic [31:7]         instr,
  output logic [ALU_XLEN-1:0] imm_i,
  output logic [ALU_XLEN-1:0] imm_s,
  output logic [ALU_XLEN-1:0] imm_u
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};

endmodule

// File: rtl/alu_operand_stage.sv
// RV32I decode + operand select in front of the ALU; accepted entry appears on OUT_* one cycle later.
// Main+skid buffer keeps IN_READY register-derived (low only when both slots hold entries).
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RegAddr = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [31:0]        IN_INSTR,
  input  logic [XLEN-1:0]    IN_PC,
  input  logic [XLEN-1:0]    IN_RS1_DATA,
  input  logic [XLEN-1:0]    IN_RS2_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [XLEN-1:0]    OUT_A,
  output logic [XLEN-1:0]    OUT_B,
  output logic [3:0]         OUT_ALU_FUN,
  output logic [RegAddr-1:0] OUT_RD,
  output logic               OUT_RD_WE,
  output logic               OUT_ILLEGAL
);

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} occ_e;

  occ_e  state_q, state_d;
  dec_t  main_q, main_d;
  dec_t  skid_q, skid_d;
  dec_t  dec;

  logic [ALU_XLEN-1:0] imm_i, imm_s, imm_u;

  rv32_imm_gen u_imm (
    .instr (IN_INSTR[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_u (imm_u)
  );

  logic [6:0]          opc;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [ALU_XLEN-1:0] shamt;
  logic [ALU_XLEN-1:0] op_a, op_b;
  logic [3:0]          fun;
  logic                legal, writes_rd;

  assign opc   = IN_INSTR[6:0];
  assign f3    = IN_INSTR[14:12];
  assign f7    = IN_INSTR[31:25];
  assign shamt = {27'b0, IN_INSTR[24:20]};

  always_comb begin
    op_a      = '0;
    op_b      = '0;
    fun       = FUN_ADD;
    legal     = 1'b1;
    writes_rd = 1'b1;
    case (opc)
      OPC_OP: begin
        op_a  = IN_RS1_DATA;
        op_b  = IN_RS2_DATA;
        fun   = {f7[5], f3};
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        op_a = IN_RS1_DATA;
        op_b = imm_i;
        fun  = {1'b0, f3};
        // Shift amounts come from the rs2 slot, so the funct7 bits must not leak into B.
        if (f3 == 3'b001) begin
          op_b  = shamt;
          legal = (f7 == 7'h00);
        end else if (f3 == 3'b101) begin
          op_b  = shamt;
          fun   = {f7[5], 3'b101};
          legal = (f7 == 7'h00) || (f7 == 7'h20);
        end
      end
      OPC_LUI: begin
        op_a = imm_u;
        fun  = FUN_LUI;
      end
      OPC_AUIPC: begin
        op_a = IN_PC;
        op_b = imm_u;
      end
      OPC_LOAD: begin
        op_a = IN_RS1_DATA;
        op_b = imm_i;
      end
      OPC_STORE: begin
        op_a      = IN_RS1_DATA;
        op_b      = imm_s;
        writes_rd = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        op_a = IN_PC;
        op_b = 32'd4;
      end
      OPC_BRANCH: begin
        op_a      = IN_RS1_DATA;
        op_b      = IN_RS2_DATA;
        writes_rd = 1'b0;
        case (f3)
          3'b000, 3'b001: fun = FUN_SUB;
          3'b100, 3'b101: fun = FUN_SLT;
          3'b110, 3'b111: fun = FUN_SLTU;
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    dec.a       = legal ? op_a : '0;
    dec.b       = legal ? op_b : '0;
    dec.fun     = legal ? fun : FUN_ADD;
    dec.rd      = IN_INSTR[11:7];
    dec.rd_we   = legal && writes_rd && (IN_INSTR[11:7] != 5'd0);
    dec.illegal = !legal;
  end

  logic accept, consume;

  assign IN_READY  = (state_q != ST_TWO);
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign accept    = IN_VALID && IN_READY;
  assign consume   = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_TWO;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign OUT_A       = main_q.a;
  assign OUT_B       = main_q.b;
  assign OUT_ALU_FUN = main_q.fun;
  assign OUT_RD      = main_q.rd;
  assign OUT_RD_WE   = main_q.rd_we;
  assign OUT_ILLEGAL = main_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: hand-computed expected entries queued on accept, compared on consume.
module tb_alu_operand_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTR;
  logic [31:0] IN_PC;
  logic [31:0] IN_RS1_DATA;
  logic [31:0] IN_RS2_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_A;
  logic [31:0] OUT_B;
  logic [3:0]  OUT_ALU_FUN;
  logic [4:0]  OUT_RD;
  logic        OUT_RD_WE;
  logic        OUT_ILLEGAL;

  alu_operand_stage #(.XLEN(32), .RegAddr(5)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_INSTR    (IN_INSTR),
    .IN_PC       (IN_PC),
    .IN_RS1_DATA (IN_RS1_DATA),
    .IN_RS2_DATA (IN_RS2_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_A       (OUT_A),
    .OUT_B       (OUT_B),
    .OUT_ALU_FUN (OUT_ALU_FUN),
    .OUT_RD      (OUT_RD),
    .OUT_RD_WE   (OUT_RD_WE),
    .OUT_ILLEGAL (OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fun;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic        chk_rd;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend_exp;
  int          checks = 0;
  int          errors = 0;
  logic        hold_vld = 1'b0;
  logic [74:0] hold_dat = '0;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fun,
                              input logic [4:0] rd, input logic we, input int tag);
    exp_t e;
    e.a = a; e.b = b; e.fun = fun; e.rd = rd; e.we = we;
    e.ill = 1'b0; e.chk_rd = 1'b1; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t mk_ill(input int tag);
    exp_t e;
    e.a = '0; e.b = '0; e.fun = 4'b0000; e.rd = '0; e.we = 1'b0;
    e.ill = 1'b1; e.chk_rd = 1'b0; e.tag = tag;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input exp_t e);
    IN_VALID    = 1'b1;
    IN_INSTR    = instr;
    IN_PC       = pc;
    IN_RS1_DATA = rs1;
    IN_RS2_DATA = rs2;
    pend_exp    = e;
  endtask

  // One clock: observe at the falling edge, then return 2ns after the rising edge.
  task automatic step_cycle();
    exp_t e;
    @(negedge CLK);
    if (RST_N && FLUSH) begin
      sb.delete();
      hold_vld = 1'b0;
    end else if (RST_N) begin
      if (hold_vld && OUT_VALID) begin
        checks++;
        if ({OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL} !== hold_dat) begin
          errors++;
          $display("FAIL stall_stable: got %h want %h",
                   {OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL}, hold_dat);
        end
      end
      hold_vld = OUT_VALID && !OUT_READY;
      hold_dat = {OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL};
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got A=%h B=%h FUN=%b, want no entry", OUT_A, OUT_B, OUT_ALU_FUN);
        end else begin
          e = sb.pop_front();
          if ({OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD_WE, OUT_ILLEGAL} !== {e.a, e.b, e.fun, e.we, e.ill} ||
              (e.chk_rd && OUT_RD !== e.rd)) begin
            errors++;
            $display("FAIL entry%0d: got A=%h B=%h FUN=%b RD=%0d WE=%b ILL=%b, want A=%h B=%h FUN=%b RD=%0d WE=%b ILL=%b",
                     e.tag, OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL,
                     e.a, e.b, e.fun, e.rd, e.we, e.ill);
          end
        end
      end
      if (IN_VALID && IN_READY) sb.push_back(pend_exp);
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic test_reset();
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: got OUT_VALID=%b IN_READY=%b, want 0 1", OUT_VALID, IN_READY);
    end
    checks++;
    if ({OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL} !== 75'd0) begin
      errors++;
      $display("FAIL reset_data: got A=%h B=%h FUN=%b RD=%0d WE=%b ILL=%b, want all 0",
               OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL);
    end
  endtask

  task automatic test_op();
    OUT_READY = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1));
    step_cycle();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_A !== 32'd5 || OUT_B !== 32'd7) begin
      errors++;
      $display("FAIL add_latency: got VALID=%b A=%h B=%h, want 1 5 7", OUT_VALID, OUT_A, OUT_B);
    end
    drive(32'h40208233, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 4'b1000, 5'd4, 1'b1, 2));
    step_cycle();
    drive(32'h40209233, 32'h0, 32'd10, 32'd3, mk_ill(3));
    step_cycle();
    drive(32'h022081B3, 32'h0, 32'd10, 32'd3, mk_ill(4));
    step_cycle();
    idle(2);
  endtask

  task automatic test_op_imm();
    OUT_READY = 1'b1;
    drive(32'h40335293, 32'h0, 32'h80000000, 32'h0, mk(32'h80000000, 32'd3, 4'b1101, 5'd5, 1'b1, 10));
    step_cycle();
    drive(32'h40331293, 32'h0, 32'h80000000, 32'h0, mk_ill(11));
    step_cycle();
    drive(32'hFFF00393, 32'h0, 32'h11, 32'h0, mk(32'h11, 32'hFFFFFFFF, 4'b0000, 5'd7, 1'b1, 12));
    step_cycle();
    idle(2);
  endtask

  task automatic test_upper();
    OUT_READY = 1'b1;
    drive(32'hABCDE0B7, 32'h0, 32'h5, 32'h6, mk(32'hABCDE000, 32'h0, 4'b1001, 5'd1, 1'b1, 20));
    step_cycle();
    drive(32'h00001117, 32'h100, 32'h5, 32'h6, mk(32'h100, 32'h1000, 4'b0000, 5'd2, 1'b1, 21));
    step_cycle();
    idle(2);
  endtask

  task automatic test_mem_ctrl();
    exp_t e;
    OUT_READY = 1'b1;
    e = mk(32'h1000, 32'hFFFFFFFC, 4'b0000, 5'd0, 1'b0, 30);
    e.chk_rd = 1'b0;
    drive(32'hFE20AE23, 32'h0, 32'h1000, 32'h2, e);
    step_cycle();
    drive(32'h0080A483, 32'h0, 32'h2000, 32'h0, mk(32'h2000, 32'd8, 4'b0000, 5'd9, 1'b1, 31));
    step_cycle();
    e = mk(32'h33, 32'h44, 4'b0011, 5'd0, 1'b0, 32);
    e.chk_rd = 1'b0;
    drive(32'h0020E063, 32'h0, 32'h33, 32'h44, e);
    step_cycle();
    drive(32'h0020A063, 32'h0, 32'h33, 32'h44, mk_ill(33));
    step_cycle();
    drive(32'h000000EF, 32'h200, 32'h0, 32'h0, mk(32'h200, 32'd4, 4'b0000, 5'd1, 1'b1, 34));
    step_cycle();
    drive(32'h00008067, 32'h300, 32'h0, 32'h0, mk(32'h300, 32'd4, 4'b0000, 5'd0, 1'b0, 35));
    step_cycle();
    drive(32'h0000007F, 32'h0, 32'h9, 32'h9, mk_ill(36));
    step_cycle();
    drive(32'h00000000, 32'h0, 32'h9, 32'h9, mk_ill(37));
    step_cycle();
    idle(2);
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive((32'(k) << 20) | 32'h513, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'(k), 4'b0000, 5'd10, 1'b1, 40 + k));
      step_cycle();
      checks++;
      if (IN_READY !== (k == 1)) begin
        errors++;
        $display("FAIL b2b_in_ready%0d: got %b want %b", k, IN_READY, (k == 1));
      end
    end
    OUT_READY = 1'b1;
    step_cycle();
    step_cycle();
    idle(2);
    checks++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got OUT_VALID=%b pending=%0d, want 0 0", OUT_VALID, sb.size());
    end
  endtask

  task automatic test_flush();
    OUT_READY = 1'b0;
    drive(32'h00100513, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'd1, 4'b0000, 5'd10, 1'b1, 50));
    step_cycle();
    drive(32'h00200513, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'd2, 4'b0000, 5'd10, 1'b1, 51));
    step_cycle();
    FLUSH = 1'b1;
    drive(32'h00300513, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'd3, 4'b0000, 5'd10, 1'b1, 52));
    step_cycle();
    FLUSH = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got OUT_VALID=%b IN_READY=%b, want 0 1", OUT_VALID, IN_READY);
    end
    OUT_READY = 1'b1;
    idle(3);
    drive(32'h00900513, 32'h0, 32'h0, 32'h0, mk(32'h0, 32'd9, 4'b0000, 5'd10, 1'b1, 53));
    step_cycle();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flush_resume: got pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    OUT_READY = 1'b0;
    drive(32'hABCDE0B7, 32'h0, 32'h0, 32'h0, mk(32'hABCDE000, 32'h0, 4'b1001, 5'd1, 1'b1, 60));
    step_cycle();
    drive(32'h00001117, 32'h100, 32'h0, 32'h0, mk(32'h100, 32'h1000, 4'b0000, 5'd2, 1'b1, 61));
    step_cycle();
    IN_VALID = 1'b0;
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL arst_hs: got OUT_VALID=%b IN_READY=%b, want 0 1", OUT_VALID, IN_READY);
    end
    checks++;
    if ({OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD, OUT_RD_WE, OUT_ILLEGAL} !== 75'd0) begin
      errors++;
      $display("FAIL arst_data: got A=%h B=%h FUN=%b RD=%0d, want all 0", OUT_A, OUT_B, OUT_ALU_FUN, OUT_RD);
    end
    sb.delete();
    hold_vld = 1'b0;
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #2;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: got OUT_VALID=%b want 0", OUT_VALID);
    end
    OUT_READY = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd20, 32'd22, mk(32'd20, 32'd22, 4'b0000, 5'd3, 1'b1, 62));
    step_cycle();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL arst_resume: got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N       = 1'b0;
    FLUSH       = 1'b0;
    IN_VALID    = 1'b0;
    IN_INSTR    = '0;
    IN_PC       = '0;
    IN_RS1_DATA = '0;
    IN_RS2_DATA = '0;
    OUT_READY   = 1'b0;
    pend_exp    = mk_ill(0);
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    test_reset();
    test_op();
    test_op_imm();
    test_upper();
    test_mem_ctrl();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
